// File: rtl/rv_ctrl_fsm.sv
// rtl/rv_ctrl_fsm.sv - multi-cycle RV32I/RV32E control FSM (fetch/decode/exec/mem/wb/trap)
// Define CU_MULDIV_EN to decode the M-extension ALU operations.
module rv_ctrl_fsm #(
  parameter int NREG        = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] INST_DATA,
  input  logic        INST_VALID,
  output logic        INST_REQ,
  input  logic        MEM_RDY,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [4:0]  RS1_ADR,
  output logic [4:0]  RS2_ADR,
  output logic [4:0]  REG_ADR,
  output logic [4:0]  ALU_OPT,
  output logic [2:0]  BR_OPT,
  output logic [2:0]  LSU_OPT,
  output logic [2:0]  IMM_TYPE,
  output logic        RS1_SEL,
  output logic        RS2_SEL,
  output logic [2:0]  REG_SEL,
  output logic        PC_SEL,
  output logic        WRITE_ENB,
  output logic        PC_EN,
  output logic        GLOBAL_RESET,
  output logic        ILLEGAL,
  output logic        TIMEOUT
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] mem_cnt;
  logic       illegal_q, timeout_q;

  logic [4:0] rs1_q, rs2_q, rd_q, alu_q;
  logic [2:0] br_q, lsu_q, imm_q, reg_sel_q;
  logic       rs1_sel_q, rs2_sel_q, pc_sel_q, has_rd_q, is_mem_q, is_store_q, bad_q;

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] d_alu;
  logic [2:0] d_br, d_lsu, d_imm, d_reg_sel;
  logic       d_rs1_sel, d_rs2_sel, d_pc_sel, d_mem, d_store, d_bad;
  logic       use_rs1, use_rs2, use_rd;

  assign opc = INST_DATA[6:0];
  assign f3  = INST_DATA[14:12];
  assign f7  = INST_DATA[31:25];

  function automatic logic reg_bad(input logic [4:0] idx);
    return int'(idx) >= NREG;
  endfunction

  function automatic logic [4:0] alu_base(input logic [2:0] fn, input logic alt);
    case (fn)
      3'b000:  return alt ? 5'd1 : 5'd0;
      3'b001:  return 5'd2;
      3'b010:  return 5'd3;
      3'b011:  return 5'd4;
      3'b100:  return 5'd5;
      3'b101:  return alt ? 5'd7 : 5'd6;
      3'b110:  return 5'd8;
      default: return 5'd9;
    endcase
  endfunction

  always_comb begin
    d_alu = 5'd0; d_br = 3'd7; d_lsu = 3'd0; d_imm = 3'd0; d_reg_sel = 3'd0;
    d_rs1_sel = 1'b0; d_rs2_sel = 1'b0; d_pc_sel = 1'b0;
    d_mem = 1'b0; d_store = 1'b0; d_bad = 1'b0;
    use_rs1 = 1'b0; use_rs2 = 1'b0; use_rd = 1'b0;
    case (opc)
      7'h37: begin d_imm = 3'd3; d_reg_sel = 3'd2; use_rd = 1'b1; end
      7'h17: begin
        d_imm = 3'd3; d_rs1_sel = 1'b1; d_rs2_sel = 1'b1; use_rd = 1'b1;
      end
      7'h6F: begin d_imm = 3'd4; d_reg_sel = 3'd4; d_br = 3'd6; use_rd = 1'b1; end
      7'h67: begin
        d_reg_sel = 3'd4; d_rs2_sel = 1'b1; d_br = 3'd6; d_pc_sel = 1'b1;
        use_rs1 = 1'b1; use_rd = 1'b1;
      end
      7'h63: begin
        d_imm = 3'd1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        case (f3)
          3'b000:  d_br = 3'd0;
          3'b001:  d_br = 3'd1;
          3'b100:  d_br = 3'd2;
          3'b101:  d_br = 3'd3;
          3'b110:  d_br = 3'd4;
          3'b111:  d_br = 3'd5;
          default: d_bad = 1'b1;
        endcase
      end
      7'h03: begin
        d_lsu = f3; d_rs2_sel = 1'b1; d_reg_sel = 3'd1; d_mem = 1'b1;
        use_rs1 = 1'b1; use_rd = 1'b1;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) d_bad = 1'b1;
      end
      7'h23: begin
        d_imm = 3'd2; d_rs2_sel = 1'b1; d_mem = 1'b1; d_store = 1'b1;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        case (f3)
          3'b000:  d_lsu = 3'd5;
          3'b001:  d_lsu = 3'd6;
          3'b010:  d_lsu = 3'd7;
          default: d_bad = 1'b1;
        endcase
      end
      // OP-IMM: funct7 only exists for the shift forms; elsewhere it is immediate
      7'h13: begin
        d_rs2_sel = 1'b1; use_rs1 = 1'b1; use_rd = 1'b1;
        d_alu = alu_base(f3, f3 == 3'b101 && f7 == 7'h20);
        if (f3 == 3'b001 && f7 != 7'h00) d_bad = 1'b1;
        if (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20) d_bad = 1'b1;
      end
      7'h33: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
        if (f7 == 7'h00) d_alu = alu_base(f3, 1'b0);
        else if (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)) d_alu = alu_base(f3, 1'b1);
`ifdef CU_MULDIV_EN
        else if (f7 == 7'h01) d_alu = {2'b10, f3};
`endif
        else d_bad = 1'b1;
      end
      7'h0F: ;
      default: d_bad = 1'b1;
    endcase
    if ((use_rs1 && reg_bad(INST_DATA[19:15])) || (use_rs2 && reg_bad(INST_DATA[24:20])) ||
        (use_rd && reg_bad(INST_DATA[11:7])))
      d_bad = 1'b1;
  end

  // Decode registers load on the accept edge and hold until the next one.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rs1_q <= 5'd0; rs2_q <= 5'd0; rd_q <= 5'd0; alu_q <= 5'd0;
      br_q <= 3'd7; lsu_q <= 3'd0; imm_q <= 3'd0; reg_sel_q <= 3'd0;
      rs1_sel_q <= 1'b0; rs2_sel_q <= 1'b0; pc_sel_q <= 1'b0;
      has_rd_q <= 1'b0; is_mem_q <= 1'b0; is_store_q <= 1'b0; bad_q <= 1'b0;
    end else if (state == S_FETCH && INST_VALID) begin
      rs1_q <= INST_DATA[19:15]; rs2_q <= INST_DATA[24:20]; rd_q <= INST_DATA[11:7];
      alu_q <= d_alu; br_q <= d_br; lsu_q <= d_lsu; imm_q <= d_imm; reg_sel_q <= d_reg_sel;
      rs1_sel_q <= d_rs1_sel; rs2_sel_q <= d_rs2_sel; pc_sel_q <= d_pc_sel;
      has_rd_q <= use_rd; is_mem_q <= d_mem; is_store_q <= d_store; bad_q <= d_bad;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   state_nxt = S_FETCH;
      S_FETCH:  if (INST_VALID) state_nxt = S_DECODE;
      S_DECODE: state_nxt = bad_q ? S_TRAP : S_EXEC;
      S_EXEC:   state_nxt = is_mem_q ? S_MEM : S_WB;
      S_MEM: begin
        if (MEM_RDY) state_nxt = S_WB;
        else if (mem_cnt == TMO_LAST) state_nxt = S_TRAP;
      end
      S_WB:     state_nxt = S_FETCH;
      S_TRAP:   state_nxt = S_TRAP;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mem_cnt <= 8'd0; illegal_q <= 1'b0; timeout_q <= 1'b0;
    end else begin
      mem_cnt <= (state == S_MEM) ? mem_cnt + 8'd1 : 8'd0;
      if (state == S_DECODE && bad_q) illegal_q <= 1'b1;
      if (state == S_MEM && !MEM_RDY && mem_cnt == TMO_LAST) timeout_q <= 1'b1;
    end
  end

  always_comb begin
    INST_REQ     = (state == S_FETCH);
    MEM_REQ      = (state == S_MEM);
    MEM_WE       = (state == S_MEM) && is_store_q;
    PC_EN        = (state == S_WB);
    WRITE_ENB    = (state == S_WB) && has_rd_q && (rd_q != 5'd0);
    GLOBAL_RESET = RST || (state == S_IDLE);
  end

  assign RS1_ADR  = rs1_q;
  assign RS2_ADR  = rs2_q;
  assign REG_ADR  = rd_q;
  assign ALU_OPT  = alu_q;
  assign BR_OPT   = br_q;
  assign LSU_OPT  = lsu_q;
  assign IMM_TYPE = imm_q;
  assign RS1_SEL  = rs1_sel_q;
  assign RS2_SEL  = rs2_sel_q;
  assign REG_SEL  = reg_sel_q;
  assign PC_SEL   = pc_sel_q;
  assign ILLEGAL  = illegal_q;
  assign TIMEOUT  = timeout_q;

endmodule

// File: tb/tb_rv_ctrl_fsm.sv
// tb/tb_rv_ctrl_fsm.sv - directed self-checking bench for rv_ctrl_fsm
// dut: NREG=32, MEM_TIMEOUT=4; d16: NREG=16, MEM_TIMEOUT=16, same stimulus.
module tb_rv_ctrl_fsm;
  logic        CLK = 1'b0;
  logic        RST, INST_VALID, MEM_RDY;
  logic [31:0] INST_DATA;
  logic        INST_REQ, MEM_REQ, MEM_WE, RS1_SEL, RS2_SEL, PC_SEL, WRITE_ENB, PC_EN;
  logic        GLOBAL_RESET, ILLEGAL, TIMEOUT;
  logic [4:0]  RS1_ADR, RS2_ADR, REG_ADR, ALU_OPT;
  logic [2:0]  BR_OPT, LSU_OPT, IMM_TYPE, REG_SEL;
  logic        b_INST_REQ, b_MEM_REQ, b_MEM_WE, b_RS1_SEL, b_RS2_SEL, b_PC_SEL, b_WRITE_ENB;
  logic        b_PC_EN, b_GLOBAL_RESET, b_ILLEGAL, b_TIMEOUT;
  logic [4:0]  b_RS1_ADR, b_RS2_ADR, b_REG_ADR, b_ALU_OPT;
  logic [2:0]  b_BR_OPT, b_LSU_OPT, b_IMM_TYPE, b_REG_SEL;
  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  rv_ctrl_fsm #(.NREG(32), .MEM_TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST), .INST_DATA(INST_DATA), .INST_VALID(INST_VALID), .INST_REQ(INST_REQ),
    .MEM_RDY(MEM_RDY), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .RS1_ADR(RS1_ADR), .RS2_ADR(RS2_ADR),
    .REG_ADR(REG_ADR), .ALU_OPT(ALU_OPT), .BR_OPT(BR_OPT), .LSU_OPT(LSU_OPT), .IMM_TYPE(IMM_TYPE),
    .RS1_SEL(RS1_SEL), .RS2_SEL(RS2_SEL), .REG_SEL(REG_SEL), .PC_SEL(PC_SEL),
    .WRITE_ENB(WRITE_ENB), .PC_EN(PC_EN), .GLOBAL_RESET(GLOBAL_RESET), .ILLEGAL(ILLEGAL),
    .TIMEOUT(TIMEOUT)
  );

  rv_ctrl_fsm #(.NREG(16), .MEM_TIMEOUT(16)) d16 (
    .CLK(CLK), .RST(RST), .INST_DATA(INST_DATA), .INST_VALID(INST_VALID), .INST_REQ(b_INST_REQ),
    .MEM_RDY(MEM_RDY), .MEM_REQ(b_MEM_REQ), .MEM_WE(b_MEM_WE), .RS1_ADR(b_RS1_ADR),
    .RS2_ADR(b_RS2_ADR), .REG_ADR(b_REG_ADR), .ALU_OPT(b_ALU_OPT), .BR_OPT(b_BR_OPT),
    .LSU_OPT(b_LSU_OPT), .IMM_TYPE(b_IMM_TYPE), .RS1_SEL(b_RS1_SEL), .RS2_SEL(b_RS2_SEL),
    .REG_SEL(b_REG_SEL), .PC_SEL(b_PC_SEL), .WRITE_ENB(b_WRITE_ENB), .PC_EN(b_PC_EN),
    .GLOBAL_RESET(b_GLOBAL_RESET), .ILLEGAL(b_ILLEGAL), .TIMEOUT(b_TIMEOUT)
  );

  task automatic step();
    @(posedge CLK); #1;
  endtask

  // Leaves both DUTs in FETCH.
  task automatic do_reset();
    RST = 1'b1; INST_VALID = 1'b0; MEM_RDY = 1'b0; INST_DATA = 32'd0;
    repeat (3) step();
    RST = 1'b0;
    step();
  endtask

  // Presents inst in FETCH; returns in cycle A+1.
  task automatic issue(input logic [31:0] inst);
    INST_DATA = inst; INST_VALID = 1'b1;
    step();
    INST_VALID = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; INST_VALID = 1'b0; MEM_RDY = 1'b0; INST_DATA = 32'd0;
    step();
    checks++; if (GLOBAL_RESET !== 1'b1) begin failures++; $display("FAIL rst_global got=%0d exp=1", GLOBAL_RESET); end
    checks++; if (BR_OPT !== 3'd7) begin failures++; $display("FAIL rst_br_opt got=%0d exp=7", BR_OPT); end
    checks++; if ({INST_REQ, MEM_REQ, MEM_WE, WRITE_ENB, PC_EN, ILLEGAL, TIMEOUT} !== 7'd0) begin failures++; $display("FAIL rst_strobes got=%b exp=0000000", {INST_REQ, MEM_REQ, MEM_WE, WRITE_ENB, PC_EN, ILLEGAL, TIMEOUT}); end
    checks++; if ({ALU_OPT, REG_ADR, LSU_OPT, IMM_TYPE, REG_SEL} !== 19'd0) begin failures++; $display("FAIL rst_decode got=%0h exp=0", {ALU_OPT, REG_ADR, LSU_OPT, IMM_TYPE, REG_SEL}); end
    repeat (2) step();
    RST = 1'b0;
    checks++; if (GLOBAL_RESET !== 1'b1 || INST_REQ !== 1'b0) begin failures++; $display("FAIL idle_cycle got=%0d%0d exp=10", GLOBAL_RESET, INST_REQ); end
    step();
    checks++; if (INST_REQ !== 1'b1 || GLOBAL_RESET !== 1'b0) begin failures++; $display("FAIL fetch_after_idle got=%0d%0d exp=10", INST_REQ, GLOBAL_RESET); end
  endtask

  task automatic test_addi();
    do_reset();
    repeat (2) step();
    checks++; if (INST_REQ !== 1'b1) begin failures++; $display("FAIL fetch_wait got=%0d exp=1", INST_REQ); end
    issue(32'h00500093);
    checks++; if (INST_REQ !== 1'b0) begin failures++; $display("FAIL addi_req_a1 got=%0d exp=0", INST_REQ); end
    checks++; if (ALU_OPT !== 5'd0 || RS2_SEL !== 1'b1 || REG_SEL !== 3'd0) begin failures++; $display("FAIL addi_ctl got=%0d/%0d/%0d exp=0/1/0", ALU_OPT, RS2_SEL, REG_SEL); end
    checks++; if (REG_ADR !== 5'd1 || BR_OPT !== 3'd7) begin failures++; $display("FAIL addi_adr got=%0d/%0d exp=1/7", REG_ADR, BR_OPT); end
    step();
    checks++; if (WRITE_ENB !== 1'b0 || PC_EN !== 1'b0) begin failures++; $display("FAIL addi_a2 got=%0d%0d exp=00", WRITE_ENB, PC_EN); end
    step();
    checks++; if (WRITE_ENB !== 1'b1 || PC_EN !== 1'b1) begin failures++; $display("FAIL addi_wb got=%0d%0d exp=11", WRITE_ENB, PC_EN); end
    step();
    checks++; if (INST_REQ !== 1'b1 || WRITE_ENB !== 1'b0 || PC_EN !== 1'b0) begin failures++; $display("FAIL addi_a4 got=%0d%0d%0d exp=100", INST_REQ, WRITE_ENB, PC_EN); end
  endtask

  task automatic test_load_wait();
    int n;
    do_reset();
    issue(32'h0040A103);
    checks++; if (LSU_OPT !== 3'd2 || REG_SEL !== 3'd1 || REG_ADR !== 5'd2) begin failures++; $display("FAIL lw_decode got=%0d/%0d/%0d exp=2/1/2", LSU_OPT, REG_SEL, REG_ADR); end
    step();
    checks++; if (MEM_REQ !== 1'b0) begin failures++; $display("FAIL lw_exec_req got=%0d exp=0", MEM_REQ); end
    n = 0;
    for (int k = 3; k <= 6; k++) begin
      step();
      if (MEM_REQ === 1'b1) n++;
      checks++; if (MEM_WE !== 1'b0 || LSU_OPT !== 3'd2) begin failures++; $display("FAIL lw_mem_stable got=%0d/%0d exp=0/2", MEM_WE, LSU_OPT); end
      if (k == 6) MEM_RDY = 1'b1;
    end
    step();
    MEM_RDY = 1'b0;
    checks++; if (n !== 4) begin failures++; $display("FAIL lw_req_cycles got=%0d exp=4", n); end
    checks++; if (WRITE_ENB !== 1'b1 || PC_EN !== 1'b1 || MEM_REQ !== 1'b0) begin failures++; $display("FAIL lw_wb_a7 got=%0d%0d%0d exp=110", WRITE_ENB, PC_EN, MEM_REQ); end
    checks++; if (TIMEOUT !== 1'b0) begin failures++; $display("FAIL lw_rdy_on_timeout_edge got=%0d exp=0", TIMEOUT); end
  endtask

  task automatic test_load_ready();
    do_reset();
    MEM_RDY = 1'b1;
    issue(32'h0000C283);
    checks++; if (LSU_OPT !== 3'd4) begin failures++; $display("FAIL lbu_lsu got=%0d exp=4", LSU_OPT); end
    repeat (2) step();
    checks++; if (MEM_REQ !== 1'b1 || WRITE_ENB !== 1'b0) begin failures++; $display("FAIL lbu_mem_a3 got=%0d%0d exp=10", MEM_REQ, WRITE_ENB); end
    step();
    MEM_RDY = 1'b0;
    checks++; if (MEM_REQ !== 1'b0 || WRITE_ENB !== 1'b1 || REG_ADR !== 5'd5) begin failures++; $display("FAIL lbu_wb_a4 got=%0d%0d/%0d exp=01/5", MEM_REQ, WRITE_ENB, REG_ADR); end
  endtask

  task automatic test_store_timeout();
    int n;
    do_reset();
    issue(32'h0020A423);
    checks++; if (IMM_TYPE !== 3'd2 || LSU_OPT !== 3'd7) begin failures++; $display("FAIL sw_decode got=%0d/%0d exp=2/7", IMM_TYPE, LSU_OPT); end
    step();
    n = 0;
    for (int k = 3; k <= 6; k++) begin
      step();
      if (MEM_REQ === 1'b1 && MEM_WE === 1'b1) n++;
    end
    step();
    checks++; if (n !== 4) begin failures++; $display("FAIL sw_req_cycles got=%0d exp=4", n); end
    checks++; if (TIMEOUT !== 1'b1 || MEM_REQ !== 1'b0) begin failures++; $display("FAIL sw_timeout got=%0d%0d exp=10", TIMEOUT, MEM_REQ); end
    repeat (3) step();
    checks++; if (PC_EN !== 1'b0 || INST_REQ !== 1'b0 || TIMEOUT !== 1'b1) begin failures++; $display("FAIL trap_hold got=%0d%0d%0d exp=001", PC_EN, INST_REQ, TIMEOUT); end
    checks++; if (b_MEM_REQ !== 1'b1) begin failures++; $display("FAIL d16_still_waiting got=%0d exp=1", b_MEM_REQ); end
    RST = 1'b1;
    step();
    RST = 1'b0;
    checks++; if (b_MEM_REQ !== 1'b0) begin failures++; $display("FAIL reset_mid_mem got=%0d exp=0", b_MEM_REQ); end
    checks++; if (TIMEOUT !== 1'b0) begin failures++; $display("FAIL timeout_clear got=%0d exp=0", TIMEOUT); end
  endtask

  task automatic test_branch_x0();
    do_reset();
    issue(32'h0020E463);
    checks++; if (BR_OPT !== 3'd4 || IMM_TYPE !== 3'd1 || RS2_SEL !== 1'b0) begin failures++; $display("FAIL bltu_decode got=%0d/%0d/%0d exp=4/1/0", BR_OPT, IMM_TYPE, RS2_SEL); end
    repeat (2) step();
    checks++; if (WRITE_ENB !== 1'b0 || PC_EN !== 1'b1) begin failures++; $display("FAIL bltu_wb got=%0d%0d exp=01", WRITE_ENB, PC_EN); end
    step();
    issue(32'h00100013);
    checks++; if (BR_OPT !== 3'd7) begin failures++; $display("FAIL addi_x0_br got=%0d exp=7", BR_OPT); end
    repeat (2) step();
    checks++; if (WRITE_ENB !== 1'b0 || PC_EN !== 1'b1) begin failures++; $display("FAIL addi_x0_wb got=%0d%0d exp=01", WRITE_ENB, PC_EN); end
  endtask

  task automatic test_jump();
    do_reset();
    issue(32'h12345237);
    checks++; if (IMM_TYPE !== 3'd3 || REG_SEL !== 3'd2 || REG_ADR !== 5'd4) begin failures++; $display("FAIL lui_decode got=%0d/%0d/%0d exp=3/2/4", IMM_TYPE, REG_SEL, REG_ADR); end
    repeat (2) step();
    checks++; if (WRITE_ENB !== 1'b1 || IMM_TYPE !== 3'd3) begin failures++; $display("FAIL lui_wb_held got=%0d/%0d exp=1/3", WRITE_ENB, IMM_TYPE); end
    step();
    issue(32'h000280E7);
    checks++; if (PC_SEL !== 1'b1 || BR_OPT !== 3'd6 || REG_SEL !== 3'd4 || RS1_ADR !== 5'd5 || RS2_SEL !== 1'b1) begin failures++; $display("FAIL jalr_decode got=%0d/%0d/%0d/%0d/%0d exp=1/6/4/5/1", PC_SEL, BR_OPT, REG_SEL, RS1_ADR, RS2_SEL); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue(32'h402081B3);
    checks++; if (ALU_OPT !== 5'd1) begin failures++; $display("FAIL sub_alu got=%0d exp=1", ALU_OPT); end
    repeat (3) step();
    checks++; if (INST_REQ !== 1'b1 || ALU_OPT !== 5'd1) begin failures++; $display("FAIL b2b_hold got=%0d/%0d exp=1/1", INST_REQ, ALU_OPT); end
    issue(32'h4020D1B3);
    checks++; if (ALU_OPT !== 5'd7 || RS1_ADR !== 5'd1 || RS2_ADR !== 5'd2) begin failures++; $display("FAIL sra_decode got=%0d/%0d/%0d exp=7/1/2", ALU_OPT, RS1_ADR, RS2_ADR); end
  endtask

  task automatic test_regidx();
    do_reset();
    issue(32'h002088B3);
    checks++; if (b_ILLEGAL !== 1'b0) begin failures++; $display("FAIL x17_ill_a1 got=%0d exp=0", b_ILLEGAL); end
    step();
    checks++; if (b_ILLEGAL !== 1'b1 || b_INST_REQ !== 1'b0) begin failures++; $display("FAIL x17_nreg16_a2 got=%0d%0d exp=10", b_ILLEGAL, b_INST_REQ); end
    checks++; if (ILLEGAL !== 1'b0) begin failures++; $display("FAIL x17_nreg32_legal got=%0d exp=0", ILLEGAL); end
    step();
    checks++; if (WRITE_ENB !== 1'b1 || REG_ADR !== 5'd17) begin failures++; $display("FAIL x17_nreg32_wb got=%0d/%0d exp=1/17", WRITE_ENB, REG_ADR); end
    checks++; if (b_PC_EN !== 1'b0 || b_WRITE_ENB !== 1'b0) begin failures++; $display("FAIL x17_nreg16_trap got=%0d%0d exp=00", b_PC_EN, b_WRITE_ENB); end
  endtask

  task automatic test_muldiv();
    do_reset();
    issue(32'h022081B3);
`ifdef CU_MULDIV_EN
    checks++; if (ALU_OPT !== 5'd16) begin failures++; $display("FAIL mul_alu got=%0d exp=16", ALU_OPT); end
    repeat (2) step();
    checks++; if (WRITE_ENB !== 1'b1 || ILLEGAL !== 1'b0) begin failures++; $display("FAIL mul_wb got=%0d%0d exp=10", WRITE_ENB, ILLEGAL); end
`else
    step();
    checks++; if (ILLEGAL !== 1'b1) begin failures++; $display("FAIL mul_illegal got=%0d exp=1", ILLEGAL); end
    step();
    checks++; if (PC_EN !== 1'b0 || WRITE_ENB !== 1'b0) begin failures++; $display("FAIL mul_trap got=%0d%0d exp=00", PC_EN, WRITE_ENB); end
`endif
  endtask

  task automatic test_illegal();
    do_reset();
    issue(32'h00000073);
    step();
    checks++; if (ILLEGAL !== 1'b1) begin failures++; $display("FAIL ecall_illegal got=%0d exp=1", ILLEGAL); end
    repeat (4) step();
    checks++; if (ILLEGAL !== 1'b1 || INST_REQ !== 1'b0 || PC_EN !== 1'b0) begin failures++; $display("FAIL ecall_sticky got=%0d%0d%0d exp=100", ILLEGAL, INST_REQ, PC_EN); end
    do_reset();
    checks++; if (ILLEGAL !== 1'b0) begin failures++; $display("FAIL illegal_clear got=%0d exp=0", ILLEGAL); end
    issue(32'h0040B103);
    step();
    checks++; if (ILLEGAL !== 1'b1) begin failures++; $display("FAIL ld_f3_011 got=%0d exp=1", ILLEGAL); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_wait();
    test_load_ready();
    test_store_timeout();
    test_branch_x0();
    test_jump();
    test_back_to_back();
    test_regidx();
    test_muldiv();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rv_ctrl_fsm.md
# rv_ctrl_fsm

Parametrised multi-cycle control unit for the RV32I/RV32E core. It sequences fetch, decode, execute, memory and write-back through a synchronous state machine and drives the register file, ALU, branch unit, LSU, immediate generator and datapath muxes. It uses valid/ready handshakes on the instruction and data memories, with a memory timeout. Illegal or unsupported instructions and memory timeouts park the core in a trap state.

## Interface
Parameters:
- NREG, 32, architectural register count; 32 (RV32I) or 16 (RV32E).
- MEM_TIMEOUT, 16, maximum cycles spent in MEM waiting for MEM_RDY; range 1..255.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  reset, synchronous, active-high.
- INST_DATA  in  32  fetched instruction.
- INST_VALID  in  1  INST_DATA valid.
- INST_REQ  out  1  fetch request.
- MEM_RDY  in  1  load data ready / store acknowledge.
- MEM_REQ  out  1  data memory request.
- MEM_WE  out  1  store qualifier for MEM_REQ.
- RS1_ADR, RS2_ADR, REG_ADR  out  5 each  register addresses.
- ALU_OPT  out  5  ALU operation.
- BR_OPT  out  3  branch operation.
- LSU_OPT  out  3  LSU size/sign operation.
- IMM_TYPE  out  3  immediate format.
- RS1_SEL  out  1  0 = rs1, 1 = PC.
- RS2_SEL  out  1  0 = rs2, 1 = imm.
- REG_SEL  out  3  write-back source.
- PC_SEL  out  1  0 = PC+imm/PC+4, 1 = ALU result.
- WRITE_ENB  out  1  register file write strobe.
- PC_EN  out  1  PC update strobe.
- GLOBAL_RESET  out  1  datapath reset.
- ILLEGAL  out  1  sticky illegal-instruction flag.
- TIMEOUT  out  1  sticky memory-timeout flag.

## Operation
- States: IDLE → FETCH → DECODE → EXEC → (MEM) → WB → FETCH. Any error goes to TRAP.
- IDLE: lasts one cycle after reset release. GLOBAL_RESET=1 while RST=1 or in IDLE.
- FETCH: INST_REQ=1 until a rising edge samples INST_VALID=1 (the accept edge). INST_DATA is latched at that edge.
- DECODE: all decode outputs are registered and held until the next DECODE.
- Opcode 37 (LUI): IMM_TYPE=3 (U), REG_SEL=2.
- Opcode 17 (AUIPC): IMM_TYPE=3, RS1_SEL=1, RS2_SEL=1, ALU_OPT=0, REG_SEL=0.
- Opcode 6F (JAL): IMM_TYPE=4, REG_SEL=4 (PC+4), BR_OPT=6, PC_SEL=0.
- Opcode 67 (JALR): IMM_TYPE=0, REG_SEL=4, RS1_SEL=0, RS2_SEL=1, ALU_OPT=0, BR_OPT=6, PC_SEL=1.
- Opcode 63 (branches): IMM_TYPE=1, RS1_SEL=0, RS2_SEL=0. BR_OPT: BEQ 0, BNE 1, BLT 2, BGE 3, BLTU 4, BGEU 5. funct3 010 and 011 are illegal.
- Opcode 03 (loads): LSU_OPT=funct3; funct3 011, 110, 111 are illegal. ALU_OPT=0, RS2_SEL=1, REG_SEL=1.
- Opcode 23 (stores): IMM_TYPE=2. LSU_OPT: 5 (SB), 6 (SH), 7 (SW); other funct3 values are illegal.
- Opcodes 13 and 33 (OP-IMM, OP): REG_SEL=0. ALU_OPT: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9.
  - SUB and SRA/SRAI require funct7=0100000; all others require funct7=0000000.
  - Any other funct7 is illegal, except as enabled in Configuration.
- Opcode 0F (FENCE): NOP; no write, PC advances.
- Opcode 73 and any other opcode: illegal.
- Illegal register index: any used rs1/rs2/rd index ≥ NREG is illegal.
- BR_OPT=7 (none) for every non-branch instruction.
- EXEC: one cycle. Loads and stores go to MEM; everything else goes to WB.
- MEM: MEM_REQ=1, MEM_WE=1 for stores.
  - A counter starts at 0 on entry and increments each cycle.
  - An edge sampling MEM_RDY=1 moves to WB.
  - If the counter reaches MEM_TIMEOUT−1 with MEM_RDY=0, go to TRAP with TIMEOUT=1.
  - When MEM_RDY=1 is sampled on the timeout edge, WB is taken.
- WB: one cycle. PC_EN=1.
  - WRITE_ENB=1 for instructions with rd, only when REG_ADR≠0.
  - Stores, branches and FENCE: WRITE_ENB=0.
- TRAP: illegal decode goes DECODE → TRAP and sets ILLEGAL=1. TRAP holds all strobes 0, no PC_EN, until RST.

## Timing
- Reset values: all outputs 0 except BR_OPT=7 and GLOBAL_RESET=1.
- Reset is taken at any state, including mid-MEM: MEM_REQ drops on the edge where RST is sampled.
- Edges are counted from the accept edge (A):
  - ALU/LUI/AUIPC/jump/branch: DECODE A+1, EXEC A+2, WB A+3. WRITE_ENB and PC_EN are high during cycle A+3 only; INST_REQ is high again at A+4.
  - Load/store with MEM_RDY already high: MEM A+3, WB A+4.
  - Each extra wait cycle adds one cycle.
- MEM_REQ, MEM_WE and LSU_OPT are stable while MEM_REQ=1.
- Decode outputs change only on the edge entering DECODE.

## Configuration
- CU_MULDIV_EN defined: opcode 33 with funct7=0000001 decodes M-extension ALU_OPT codes: MUL 16, MULH 17, MULHSU 18, MULHU 19, DIV 20, DIVU 21, REM 22, REMU 23.
- CU_MULDIV_EN undefined: those encodings are illegal → TRAP.

## Test plan
- Reset 3 cycles, then ADDI x1,x0,5 (00500093) valid immediately → INST_REQ high cycle 1 after IDLE; ALU_OPT=0, RS2_SEL=1; WRITE_ENB=1 and PC_EN=1 exactly at A+3, REG_ADR=1.
- LW x2,4(x1) (0040A103), MEM_RDY delayed 3 cycles → MEM_REQ high 4 cycles, MEM_WE=0, LSU_OPT=2, REG_SEL=1, WRITE_ENB at A+7.
- SW with MEM_RDY never asserted, MEM_TIMEOUT=4 → MEM_REQ high 4 cycles, then TIMEOUT=1, no PC_EN; RST clears TIMEOUT.
- BLTU (funct3 110) → BR_OPT=4, WRITE_ENB=0, PC_EN=1. ADDI x0 → WRITE_ENB=0.
- NREG=16 with ADD x17,x1,x2 → ILLEGAL=1 at A+2; with NREG=32 it executes.
- MUL x3,x1,x2 (022081B3) → ALU_OPT=16 when CU_MULDIV_EN is defined; ILLEGAL=1 when it is not.
